// File: rtl/router_pkt_tx.sv
// ============================================================================
// Module   : router_pkt_tx
// Purpose  : Packet transmitter feeding the router 1x3 input port
//            (data_in / pkt_valid / busy side). A request (addr, len) is
//            accepted, the full payload is buffered, and the packet is then
//            sent gap-free as header {len,addr}, len payload bytes and one
//            XOR parity byte. Router busy stalls the byte on data_out.
// Optional : ROUTER_TX_ERR_INJECT_EN adds input err_inject. When it is high
//            at the last payload load, the parity byte is sent inverted.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            req_valid/ready - request handshake; req_addr[1:0], req_len[5:0]
//            req_err         - 1-cycle pulse, request rejected
//            pl_valid/ready  - payload handshake; pl_data[7:0]
//            busy            - router back-pressure, holds the output byte
//            data_out[7:0]   - byte to router data_in (registered)
//            pkt_valid       - to router pkt_valid (registered)
//            tx_active       - high while header/payload/parity are on the wire
//            pkt_done        - 1-cycle pulse after the parity byte is taken
//            err_inject      - (ROUTER_TX_ERR_INJECT_EN only) corrupt parity
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module router_pkt_tx #(
  parameter int MAX_LEN  = 63,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
`ifdef ROUTER_TX_ERR_INJECT_EN
  input  logic       err_inject,
`endif
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  output logic       req_err,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HDR  = 3'd2,
    S_PLD  = 3'd3,
    S_PAR  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  localparam int               GAP_W     = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IDLE_GAP - 1);
  localparam logic [6:0]       LEN_LIMIT = 7'(MAX_LEN);

  state_t           state;
  logic [1:0]       addr_q;
  logic [5:0]       len_q;
  logic [7:0]       parity;
  logic [5:0]       cnt;
  logic [5:0]       idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       pkt_buf [0:MAX_LEN-1];

  logic [7:0] header;
  logic [7:0] par_out;
  logic       req_hs;
  logic       req_bad;
  logic       pl_hs;
  logic       last_byte;
  logic       taken;

  assign header    = {len_q, addr_q};
  // Ready strobes are state decodes, forced low while reset is asserted so
  // nothing is handshaken in the reset cycle itself.
  assign req_ready = (state == S_IDLE) && !reset;
  assign pl_ready  = (state == S_LOAD) && !reset;
  assign req_hs    = req_valid && req_ready;
  assign pl_hs     = pl_valid && pl_ready;
  assign req_bad   = (req_len == 6'd0) || (req_addr == 2'd3) ||
                     ({1'b0, req_len} > LEN_LIMIT);
  assign last_byte = (cnt == len_q - 6'd1);
  // The byte on data_out is consumed by the router on any edge without busy.
  assign taken     = !busy;

`ifdef ROUTER_TX_ERR_INJECT_EN
  logic inv_par;

  // Captured once per packet, at the edge that completes the payload load.
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_par <= 1'b0;
    end else if (pl_hs && last_byte) begin
      inv_par <= err_inject;
    end
  end

  assign par_out = inv_par ? ~parity : parity;
`else
  assign par_out = parity;
`endif

  // Payload buffer: plain storage, no reset needed since every byte read
  // out was written during the preceding LOAD.
  always_ff @(posedge clk) begin
    if (pl_hs) begin
      pkt_buf[cnt] <= pl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      parity    <= 8'd0;
      cnt       <= 6'd0;
      idx       <= 6'd0;
      gap_cnt   <= '0;
      data_out  <= 8'd0;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      req_err   <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      req_err  <= 1'b0;
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_hs) begin
            if (req_bad) begin
              req_err <= 1'b1;
            end else begin
              addr_q <= req_addr;
              len_q  <= req_len;
              // Parity covers the header too, so seed it with the header.
              parity <= {req_len, req_addr};
              cnt    <= 6'd0;
              state  <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (pl_hs) begin
            parity <= parity ^ pl_data;
            cnt    <= cnt + 6'd1;
            if (last_byte) begin
              // Header goes out on the same edge the last byte lands.
              data_out  <= header;
              pkt_valid <= 1'b1;
              tx_active <= 1'b1;
              state     <= S_HDR;
            end
          end
        end

        S_HDR: begin
          if (taken) begin
            data_out <= pkt_buf[0];
            idx      <= 6'd1;
            state    <= S_PLD;
          end
        end

        S_PLD: begin
          if (taken) begin
            if (idx < len_q) begin
              data_out <= pkt_buf[idx];
              idx      <= idx + 6'd1;
            end else begin
              // Last payload byte consumed: parity follows with pkt_valid low.
              data_out  <= par_out;
              pkt_valid <= 1'b0;
              state     <= S_PAR;
            end
          end
        end

        S_PAR: begin
          if (taken) begin
            pkt_done  <= 1'b1;
            data_out  <= 8'd0;
            tx_active <= 1'b0;
            gap_cnt   <= '0;
            state     <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
// ============================================================================
// Module   : tb_router_pkt_tx
// Purpose  : Self-checking bench for router_pkt_tx. A table of packet
//            vectors carries hand-computed header and parity bytes; each is
//            loaded, transmitted with optional busy stalls, and compared byte
//            by byte. Hand-written sequences cover bad requests, reset during
//            transmission and (with ROUTER_TX_ERR_INJECT_EN) parity inversion.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_router_pkt_tx;

  localparam int IDLE_GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_err;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       pkt_done;
`ifdef ROUTER_TX_ERR_INJECT_EN
  logic       err_inject;
`endif

  router_pkt_tx #(.MAX_LEN(63), .IDLE_GAP(IDLE_GAP)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ROUTER_TX_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_err   (req_err),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .tx_active (tx_active),
    .pkt_done  (pkt_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    logic [7:0] base;       // payload byte i = base + i
    int         stall_pos;  // output position held by busy (0=header), -1 none
    int         stall_cyc;
    bit         gappy;      // pl_valid toggles 1/0 during load
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for req_ready then performs one request handshake; returns at the
  // negedge following the handshake edge.
  task automatic do_req(input logic [1:0] a, input logic [5:0] l);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] l, input logic [7:0] base, input bit gappy);
    int  i = 0;
    int  n = 0;
    bit  phase = 1'b0;
    bit  tk;
    while (i < int'(l) && n < 400) begin
      if (gappy && phase) begin
        pl_valid = 1'b0;
      end else begin
        pl_valid = 1'b1;
        pl_data  = base + 8'(i);
      end
      tk = pl_valid && pl_ready;
      @(posedge clk);
      if (tk) i++;
      phase = ~phase;
      n++;
      @(negedge clk);
    end
    pl_valid = 1'b0;
    check("load_bytes_accepted", 32'(i), 32'(l));
    check("pl_ready_after_load", 32'(pl_ready), 32'd0);
  endtask

  // Starts at the negedge where the header should be on data_out.
  task automatic do_tx(input logic [5:0] l, input logic [7:0] base,
                       input logic [7:0] hdr, input logic [7:0] par,
                       input int stall_pos, input int stall_cyc);
    int         pos = 0;
    int         n = 0;
    int         stalled = 0;
    logic [7:0] expb;
    while (pos < int'(l) + 2 && n < 500) begin
      if (pos == 0)            expb = hdr;
      else if (pos <= int'(l)) expb = base + 8'(pos - 1);
      else                     expb = par;
      check($sformatf("data_out_pos%0d", pos), 32'(data_out), 32'(expb));
      check($sformatf("pkt_valid_pos%0d", pos), 32'(pkt_valid), 32'(pos <= int'(l)));
      check($sformatf("tx_active_pos%0d", pos), 32'(tx_active), 32'd1);
      if (pos == stall_pos && stalled < stall_cyc) begin
        busy = 1'b1;
        stalled++;
      end else begin
        busy = 1'b0;
        pos++;
      end
      @(negedge clk);
      n++;
    end
    busy = 1'b0;
    check("tx_completed_in_budget", 32'(pos), 32'(int'(l) + 2));
    check("pkt_done_pulse", 32'(pkt_done), 32'd1);
    check("data_out_after_par", 32'(data_out), 32'd0);
    check("pkt_valid_after_par", 32'(pkt_valid), 32'd0);
    check("tx_active_after_par", 32'(tx_active), 32'd0);
    check("req_ready_in_gap", 32'(req_ready), 32'd0);
    for (int g = 1; g < IDLE_GAP; g++) begin
      @(negedge clk);
      check("pkt_done_single", 32'(pkt_done), 32'd0);
      check("req_ready_in_gap", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    check("req_ready_after_gap", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd1, 6'd10, 8'h00, -1, 0, 1'b0, 8'h29, 8'h28};  // T1
    vecs[1] = '{2'd0, 6'd1,  8'hA5,  2, 2, 1'b0, 8'h04, 8'hA1};  // stall on parity
    vecs[2] = '{2'd2, 6'd4,  8'h10,  0, 2, 1'b0, 8'h12, 8'h12};  // stall on header
    vecs[3] = '{2'd2, 6'd5,  8'h30,  4, 3, 1'b0, 8'h16, 8'h22};  // T2
    vecs[4] = '{2'd0, 6'd63, 8'h00, -1, 0, 1'b0, 8'hFC, 8'hC3};  // max length
    vecs[5] = '{2'd1, 6'd8,  8'h80, -1, 0, 1'b1, 8'h21, 8'h21};  // T4

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 2'd0;
    req_len   = 6'd0;
    pl_valid  = 1'b0;
    pl_data   = 8'd0;
    busy      = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
    err_inject = 1'b0;
`endif

    // Reset state, sampled while reset is still asserted.
    @(negedge clk);
    @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_pl_ready", 32'(pl_ready), 32'd0);
    check("rst_req_err", 32'(req_err), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_tx_active", 32'(tx_active), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[k]) begin
      do_req(vecs[k].addr, vecs[k].len);
      do_load(vecs[k].len, vecs[k].base, vecs[k].gappy);
      do_tx(vecs[k].len, vecs[k].base, vecs[k].exp_hdr, vecs[k].exp_par,
            vecs[k].stall_pos, vecs[k].stall_cyc);
    end

    // T3: zero length, then address 3, both rejected.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 2'd1; req_len = 6'd0;
    @(negedge clk);
    req_valid = 1'b0;
    check("t3_len0_req_err", 32'(req_err), 32'd1);
    check("t3_len0_pkt_valid", 32'(pkt_valid), 32'd0);
    check("t3_len0_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = 2'd3; req_len = 6'd5;
    @(negedge clk);
    req_valid = 1'b0;
    check("t3_addr3_req_err", 32'(req_err), 32'd1);
    check("t3_addr3_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("t3_req_err_cleared", 32'(req_err), 32'd0);
    check("t3_still_idle", 32'(pl_ready), 32'd0);

    // T5: reset while payload is being sent, then a fresh packet.
    do_req(2'd1, 6'd10);
    do_load(6'd10, 8'h00, 1'b0);
    busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_pld_pkt_valid", 32'(pkt_valid), 32'd1);
    req_valid = 1'b1; req_addr = 2'd0; req_len = 6'd2;
    #1;
    check("t5_req_ignored_busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    check("t5_data_out", 32'(data_out), 32'd0);
    check("t5_pkt_valid", 32'(pkt_valid), 32'd0);
    check("t5_req_ready", 32'(req_ready), 32'd1);
    check("t5_tx_active", 32'(tx_active), 32'd0);
    do_req(2'd2, 6'd3);
    do_load(6'd3, 8'hF0, 1'b0);
    do_tx(6'd3, 8'hF0, 8'h0E, 8'hFD, -1, 0);

`ifdef ROUTER_TX_ERR_INJECT_EN
    // T6: parity byte inverted (true parity 0x11).
    do_req(2'd1, 6'd4);
    err_inject = 1'b1;
    do_load(6'd4, 8'h10, 1'b0);
    err_inject = 1'b0;
    do_tx(6'd4, 8'h10, 8'h11, 8'hEE, -1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
